// File: rtl/cache_responder_pkg.sv
// Shared types for the direct-mapped write-back cache responder: opcodes,
// FSM states and the address split helper.
package cachepkg;

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_INVALIDATE = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_REL,
    S_FILL_REQ,
    S_FILL_REL,
    S_RESPOND
  } state_t;

  // Widest address the split helper handles; callers truncate to their own widths.
  localparam int MAX_AW = 64;

  typedef struct packed {
    logic [MAX_AW-1:0] index;
    logic [MAX_AW-1:0] tag;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [MAX_AW-1:0] addr,
                                             input int index_bits);
    addr_split_t s;
    s.index = addr & ((MAX_AW'(1) << index_bits) - MAX_AW'(1));
    s.tag   = addr >> index_bits;
    return s;
  endfunction

endpackage

// File: rtl/cache_responder_if.sv
// Upstream request/valid handshake plus the downstream memory handshake,
// bundled so the cache has a single bus port.
interface cache_responder_if
  import cachepkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32
) ();

  op_t                     operation;
  logic [ADDRESSWIDTH-1:0] addr_in;
  logic [DATAWIDTH-1:0]    d_in;
  logic                    request;
  logic                    valid;
  logic [DATAWIDTH-1:0]    d_out;
  logic [ADDRESSWIDTH-1:0] addr_out;
  logic                    evict;

  logic                    mem_request;
  logic                    mem_write;
  logic [ADDRESSWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0]    mem_wdata;
  logic [DATAWIDTH-1:0]    mem_rdata;
  logic                    mem_valid;

  // The cache: slave upstream, master downstream.
  modport slave (
    input  operation, addr_in, d_in, request, mem_rdata, mem_valid,
    output valid, d_out, addr_out, evict,
    output mem_request, mem_write, mem_addr, mem_wdata
  );

  // The environment: processor driver upstream, memory model downstream.
  modport master (
    output operation, addr_in, d_in, request, mem_rdata, mem_valid,
    input  valid, d_out, addr_out, evict,
    input  mem_request, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_responder_line_store.sv
// Per-line valid/dirty/tag/data storage with one combinational lookup port
// and one synchronous write port.
module cache_line_store #(
  parameter int DATAWIDTH = 8,
  parameter int TAGWIDTH  = 28,
  parameter int INDEXBITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INDEXBITS-1:0] lookup_index,
  output logic                 lookup_valid,
  output logic                 lookup_dirty,
  output logic [TAGWIDTH-1:0]  lookup_tag,
  output logic [DATAWIDTH-1:0] lookup_data,
  input  logic                 we,
  input  logic [INDEXBITS-1:0] write_index,
  input  logic                 write_valid,
  input  logic                 write_dirty,
  input  logic [TAGWIDTH-1:0]  write_tag,
  input  logic [DATAWIDTH-1:0] write_data
);

  localparam int NUM_LINES = 2 ** INDEXBITS;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAGWIDTH-1:0]  tag_q  [NUM_LINES];
  logic [DATAWIDTH-1:0] data_q [NUM_LINES];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[write_index] <= write_valid;
      dirty_q[write_index] <= write_dirty;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits
  // already mask their contents and a resettable array would not map to RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      tag_q[write_index]  <= write_tag;
      data_q[write_index] <= write_data;
    end
  end

  assign lookup_valid = valid_q[lookup_index];
  assign lookup_dirty = dirty_q[lookup_index];
  assign lookup_tag   = tag_q[lookup_index];
  assign lookup_data  = data_q[lookup_index];

endmodule

// File: rtl/cache_responder.sv
// Direct-mapped, write-back, write-allocate cache: FSM, upstream 4-phase
// responder and downstream 4-phase requester for write-backs and fills.
module cache_responder
  import cachepkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int INDEXBITS    = 4
) (
  input  logic              clock,
  input  logic              reset,
  cache_responder_if.slave  bus
);

  localparam int TAGWIDTH = ADDRESSWIDTH - INDEXBITS;

  state_t                  state, state_next;
  op_t                     op_r;
  logic [ADDRESSWIDTH-1:0] addr_r;
  logic [DATAWIDTH-1:0]    din_r;
  logic [DATAWIDTH-1:0]    d_out_r;
  logic [ADDRESSWIDTH-1:0] addr_out_r;
  logic                    evict_r;

  addr_split_t             split;
  logic [INDEXBITS-1:0]    index;
  logic [TAGWIDTH-1:0]     tag;
  logic                    unused_split;

  logic                    lk_valid, lk_dirty;
  logic [TAGWIDTH-1:0]     lk_tag;
  logic [DATAWIDTH-1:0]    lk_data;
  logic                    hit, victim_dirty;
  logic [ADDRESSWIDTH-1:0] victim_addr;

  logic                    we, w_valid, w_dirty;
  logic [DATAWIDTH-1:0]    w_data;

  assign split        = split_addr(MAX_AW'(addr_r), INDEXBITS);
  assign index        = split.index[INDEXBITS-1:0];
  assign tag          = split.tag[TAGWIDTH-1:0];
  assign unused_split = ^{split.index[MAX_AW-1:INDEXBITS], split.tag[MAX_AW-1:TAGWIDTH]};

  cache_line_store #(
    .DATAWIDTH (DATAWIDTH),
    .TAGWIDTH  (TAGWIDTH),
    .INDEXBITS (INDEXBITS)
  ) u_store (
    .clock        (clock),
    .reset        (reset),
    .lookup_index (index),
    .lookup_valid (lk_valid),
    .lookup_dirty (lk_dirty),
    .lookup_tag   (lk_tag),
    .lookup_data  (lk_data),
    .we           (we),
    .write_index  (index),
    .write_valid  (w_valid),
    .write_dirty  (w_dirty),
    .write_tag    (tag),
    .write_data   (w_data)
  );

  assign hit          = lk_valid && (lk_tag == tag);
  assign victim_dirty = lk_valid && lk_dirty;
  assign victim_addr  = {lk_tag, index};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    w_valid    = 1'b0;
    w_dirty    = 1'b0;
    w_data     = din_r;
    unique case (state)
      S_IDLE: if (bus.request) state_next = S_LOOKUP;
      S_LOOKUP: begin
        case (op_r)
          OP_READ: begin
            if (hit)               state_next = S_RESPOND;
            else if (victim_dirty) state_next = S_WB_REQ;
            else                   state_next = S_FILL_REQ;
          end
          OP_WRITE: begin
            if (!hit && victim_dirty) begin
              state_next = S_WB_REQ;
            end else begin
              {we, w_valid, w_dirty} = 3'b111;
              state_next = S_RESPOND;
            end
          end
          OP_INVALIDATE: begin
            if (hit && lk_dirty) begin
              state_next = S_WB_REQ;
            end else begin
              we         = hit;
              state_next = S_RESPOND;
            end
          end
          default: state_next = S_RESPOND;
        endcase
      end
      S_WB_REQ: if (bus.mem_valid) state_next = S_WB_REL;
      S_WB_REL: begin
        if (!bus.mem_valid) begin
          case (op_r)
            OP_READ:  state_next = S_FILL_REQ;
            OP_WRITE: begin
              {we, w_valid, w_dirty} = 3'b111;
              state_next = S_RESPOND;
            end
            OP_INVALIDATE: begin
              we         = 1'b1;
              state_next = S_RESPOND;
            end
            default: state_next = S_RESPOND;
          endcase
        end
      end
      S_FILL_REQ: begin
        if (bus.mem_valid) begin
          we         = 1'b1;
          w_valid    = 1'b1;
          w_data     = bus.mem_rdata;
          state_next = S_FILL_REL;
        end
      end
      S_FILL_REL: if (!bus.mem_valid) state_next = S_RESPOND;
      S_RESPOND:  if (!bus.request)   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r       <= OP_READ;
      addr_r     <= '0;
      din_r      <= '0;
      d_out_r    <= '0;
      addr_out_r <= '0;
      evict_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.request) begin
            op_r   <= bus.operation;
            addr_r <= bus.addr_in;
            din_r  <= bus.d_in;
          end
        end
        S_LOOKUP: begin
          if (op_r != OP_READ) d_out_r <= '0;
          else if (hit)        d_out_r <= lk_data;
        end
        S_WB_REQ: begin
          evict_r    <= 1'b1;
          addr_out_r <= victim_addr;
        end
        S_FILL_REQ: if (bus.mem_valid) d_out_r <= bus.mem_rdata;
        S_RESPOND:  if (!bus.request)  evict_r <= 1'b0;
        default: ;
      endcase
      // Without a write-back the reported address is the requested one.
      if (state != S_RESPOND && state_next == S_RESPOND && !evict_r) addr_out_r <= addr_r;
    end
  end

  // Handshake outputs decode the state so a reset drops them at once.
  assign bus.valid       = (state == S_RESPOND);
  assign bus.d_out       = d_out_r;
  assign bus.addr_out    = addr_out_r;
  assign bus.evict       = evict_r;
  assign bus.mem_request = (state == S_WB_REQ) || (state == S_FILL_REQ);
  assign bus.mem_write   = (state == S_WB_REQ);
  assign bus.mem_addr    = (state == S_WB_REQ)   ? victim_addr :
                           (state == S_FILL_REQ) ? addr_r : '0;
  assign bus.mem_wdata   = (state == S_WB_REQ)   ? lk_data : '0;

endmodule

// File: tb/tb_cache_responder.sv
// Bench for cache_responder: a cache/memory reference model feeds expected
// responses and downstream transactions to a monitor and a memory responder.
module tb_cache_responder;
  import cachepkg::*;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int IB = 4;
  localparam int NL = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_responder_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW)) bus ();

  cache_responder #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .INDEXBITS(IB)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;
  bit     mem_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    bit            chk_d;
    logic [AW-1:0] addr;
    logic          evict;
    int            lat;
  } resp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mtx_t;

  resp_t resp_q[$];
  mtx_t  mem_q[$];

  // Reference cache state and two views of backing memory: gold_mem is what
  // the model believes, store_mem is what the memory responder actually holds.
  bit            m_valid [NL];
  bit            m_dirty [NL];
  int unsigned   m_tag   [NL];
  logic [DW-1:0] m_data  [NL];
  logic [DW-1:0] gold_mem  [int unsigned];
  logic [DW-1:0] store_mem [int unsigned];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_init(input int unsigned a);
    if (a == 32'h10) return 8'hA5;
    if (a == 32'h13) return 8'h77;
    return 8'(a) ^ 8'h3C;
  endfunction

  function automatic logic [DW-1:0] gold_read(input int unsigned a);
    return gold_mem.exists(a) ? gold_mem[a] : mem_init(a);
  endfunction

  function automatic logic [DW-1:0] store_read(input int unsigned a);
    return store_mem.exists(a) ? store_mem[a] : mem_init(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_op(input logic [1:0] op, input int unsigned a, input logic [DW-1:0] din);
    int unsigned idx = a % NL;
    int unsigned tg  = a / NL;
    int unsigned victim = m_tag[idx] * NL + idx;
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    bit          wb  = 1'b0;
    bit          fill = 1'b0;
    resp_t       r = '{d: '0, chk_d: 1'b0, addr: a, evict: 1'b0, lat: 0};
    case (op)
      2'd0: begin
        r.chk_d = 1'b1;
        if (!hit) begin
          wb   = m_valid[idx] && m_dirty[idx];
          fill = 1'b1;
        end
      end
      2'd1: wb = !hit && m_valid[idx] && m_dirty[idx];
      2'd2: wb = hit && m_dirty[idx];
      default: r.chk_d = 1'b1;
    endcase
    if (wb) begin
      mem_q.push_back('{wr: 1'b1, addr: victim, data: m_data[idx]});
      gold_mem[victim] = m_data[idx];
      r.evict = 1'b1;
      r.addr  = victim;
    end
    case (op)
      2'd0: begin
        if (fill) begin
          mem_q.push_back('{wr: 1'b0, addr: a, data: '0});
          m_valid[idx] = 1'b1;
          m_dirty[idx] = 1'b0;
          m_tag[idx]   = tg;
          m_data[idx]  = gold_read(a);
        end
        r.d = m_data[idx];
      end
      2'd1: begin
        m_valid[idx] = 1'b1;
        m_dirty[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = din;
      end
      2'd2: if (hit) begin
        m_valid[idx] = 1'b0;
        m_dirty[idx] = 1'b0;
      end
      default: ;
    endcase
    r.lat = (wb || fill) ? 0 : 2;
    resp_q.push_back(r);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] din,
                       input int hold, input bit early);
    model_op(op, a, din);
    @(posedge clk); #1;
    bus.operation = op_t'(op);
    bus.addr_in   = a;
    bus.d_in      = din;
    bus.request   = 1'b1;
    if (early) begin
      @(posedge clk); #1;
      bus.request = 1'b0;
    end
    for (int n = 0; n < 400 && !bus.valid; n++) @(negedge clk);
    check("valid_rise", bus.valid, 1);
    if (!early) begin
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      bus.request = 1'b0;
    end
    for (int n = 0; n < 20 && bus.valid; n++) @(negedge clk);
    check("valid_fall", bus.valid, 0);
  endtask

  // Upstream monitor: pops one expected response per valid rise and keeps
  // checking it for as long as valid is held.
  bit     req_seen = 1'b0;
  bit     vprev    = 1'b0;
  longint req_cyc  = 0;
  resp_t  cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_seen = 1'b0;
      vprev    = 1'b0;
    end else begin
      if (bus.request && !bus.valid && !req_seen) begin
        req_seen = 1'b1;
        req_cyc  = cyc;
      end
      if (bus.valid && !vprev) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", bus.valid, 0);
        end else begin
          cur = resp_q.pop_front();
          if (cur.chk_d) check("d_out", bus.d_out, cur.d);
          check("addr_out", bus.addr_out, cur.addr);
          check("evict", bus.evict, cur.evict);
          if (cur.lat != 0) check("hit_latency", cyc - req_cyc, cur.lat);
        end
        req_seen = 1'b0;
      end else if (bus.valid) begin
        if (cur.chk_d) check("d_out_hold", bus.d_out, cur.d);
        check("addr_out_hold", bus.addr_out, cur.addr);
        check("evict_hold", bus.evict, cur.evict);
        check("no_mem_during_hold", bus.mem_request, 0);
      end
      vprev = bus.valid;
    end
  end

  // Downstream memory responder with random handshake delays.
  initial begin
    mtx_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_request && !mem_hold) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (mem_q.size() == 0) begin
          check("mem_unexpected", bus.mem_request, 0);
        end else begin
          e = mem_q.pop_front();
          check("mem_write", bus.mem_write, e.wr);
          check("mem_addr", bus.mem_addr, e.addr);
          if (e.wr) check("mem_wdata", bus.mem_wdata, e.data);
        end
        if (bus.mem_write) store_mem[bus.mem_addr] = bus.mem_wdata;
        else               bus.mem_rdata = store_read(bus.mem_addr);
        bus.mem_valid = 1'b1;
        for (int n = 0; n < 50 && bus.mem_request; n++) @(negedge clk);
        check("mem_req_release", bus.mem_request, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 8'($urandom);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    bus.operation = OP_READ;
    bus.addr_in   = '0;
    bus.d_in      = '0;
    bus.request   = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    model_reset();

    #3;
    check("rst_valid", bus.valid, 0);
    check("rst_d_out", bus.d_out, 0);
    check("rst_addr_out", bus.addr_out, 0);
    check("rst_evict", bus.evict, 0);
    check("rst_mem_request", bus.mem_request, 0);
    #20 rst_n = 1'b1;

    do_op(2'd0, 32'h10, 8'h00, 0, 1'b0);   // cold read, fill 0xA5
    do_op(2'd0, 32'h10, 8'h00, 0, 1'b0);   // hit
    do_op(2'd1, 32'h23, 8'h5C, 0, 1'b0);   // cold write, no traffic
    do_op(2'd0, 32'h23, 8'h00, 0, 1'b0);   // hit 0x5C
    do_op(2'd0, 32'h13, 8'h00, 0, 1'b0);   // evict 0x23, fill 0x77
    do_op(2'd1, 32'h24, 8'h11, 0, 1'b0);
    do_op(2'd2, 32'h24, 8'h00, 0, 1'b0);   // dirty invalidate
    do_op(2'd2, 32'h24, 8'h00, 0, 1'b0);   // now a miss, no traffic
    do_op(2'd0, 32'h24, 8'h00, 0, 1'b0);   // miss, refetch 0x11
    do_op(2'd3, 32'h55, 8'hEE, 0, 1'b0);   // undefined opcode
    do_op(2'd0, 32'h10, 8'h00, 0, 1'b1);   // request dropped early
    do_op(2'd1, 32'h10, 8'h9B, 5, 1'b0);   // long hold after valid

    // Reset while the fill request is outstanding.
    mem_hold = 1'b1;
    @(posedge clk); #1;
    bus.operation = OP_READ;
    bus.addr_in   = 32'h35;
    bus.request   = 1'b1;
    for (int n = 0; n < 20 && !bus.mem_request; n++) @(negedge clk);
    check("abort_fill_req", bus.mem_request, 1);
    check("abort_fill_addr", bus.mem_addr, 32'h35);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_request", bus.mem_request, 0);
    check("abort_valid", bus.valid, 0);
    bus.request = 1'b0;
    model_reset();
    #4 rst_n = 1'b1;
    mem_hold = 1'b0;
    do_op(2'd0, 32'h10, 8'h00, 0, 1'b0);   // dirty 0x10 was lost: miss

    for (int i = 0; i < 150; i++) begin
      int unsigned sel = $urandom_range(0, 4);
      int unsigned tg  = (sel < 4) ? sel : 32'h0ABCDE5;
      int unsigned a   = tg * NL + $urandom_range(0, 3);
      int unsigned r   = $urandom_range(0, 99);
      logic [1:0]  op  = (r < 45) ? 2'd0 : (r < 85) ? 2'd1 : (r < 97) ? 2'd2 : 2'd3;
      do_op(op, a, 8'($urandom), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    repeat (10) @(negedge clk);
    check("resp_q_drained", resp_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
